invader_missile_pool: RTL and testbench
=======================================

// Module: invader_missile_pool
// PURPOSE
// - Parametrised pool of invader missiles. NUM_MISSILES independent slots, each IDLE or ACTIVE.
// - Launches from a pseudo-random alive column, at that column's lowest alive row.
// - Moves missiles down once per frame and retires them on screen-bottom or player hit.
// - Sits between the invader formation logic and the collision/render stages.
// PARAMETERS
// NUM_MISSILES   3     number of missile slots (1..8)
// COORD_W        10    pixel coordinate width
// NUM_COLS       11    invader columns
// ROW_W          3     width of the per-column bottom-row index
// MISSILE_STEP   2     pixels moved per frame
// FIRE_COOLDOWN  24    frames between launches (8-bit counter)
// LFSR_SEED      16'hACE1  reset value of the column-select LFSR (nonzero)
// PORTS
// clk           in   1                 clock
// rst           in   1                 async active-high reset
// frame         in   1                 1-cycle pulse per video frame
// game_clear    in   1                 sync restart: retire all missiles
// enable        in   1                 launches allowed when high; movement unaffected
// invaders_x    in   COORD_W           formation top-left x
// invaders_y    in   COORD_W           formation top-left y
// col_alive     in   NUM_COLS          bit c = column c has a live invader
// col_bottom    in   NUM_COLS*ROW_W    lowest alive row per column
// hit           in   NUM_MISSILES      bit i pulse = slot i hit player/shield
// m_valid       out  NUM_MISSILES      slot active
// m_x, m_y      out  NUM_MISSILES*COORD_W  packed slot positions; slot i at [i*COORD_W +: COORD_W]
// fire          out  1                 1-cycle pulse on launch (for sound)
// BEHAVIOUR
// - Reset state:
//   - m_valid=0; all m_x/m_y=0; fire=0.
//   - cooldown=FIRE_COOLDOWN; lfsr=LFSR_SEED; spawn FSM=WAIT.
// - LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clk; not cleared by game_clear.
// - Per-slot priority each cycle: game_clear > hit[i] > frame move.
//   - hit on an IDLE slot is ignored.
//   - Move on frame: y_next = y + MISSILE_STEP. If y_next >= RES_V - PROJ_HEIGHT_SCALED, slot goes IDLE
//     (y holds its last value); otherwise y <= y_next. x is constant while ACTIVE.
// - Cooldown: decrements on frame, saturates at 0; reloads FIRE_COOLDOWN on launch and on game_clear.
// - Spawn FSM:
//   - WAIT -> PICK when cooldown==0 && enable && |col_alive && any slot IDLE.
//   - PICK: col = lfsr[7:0] mod NUM_COLS; tries=0 -> SCAN.
//   - SCAN, one column per cycle:
//     - if col_alive[col] -> LAUNCH.
//     - else col = (col==NUM_COLS-1) ? 0 : col+1; tries++.
//     - tries==NUM_COLS -> WAIT with no launch.
//   - LAUNCH, one cycle: lowest-index IDLE slot (sampled this cycle) becomes ACTIVE.
//     - x = invaders_x + col*INVADERS_OFFSET_H + SPRITE_WIDTH_SCALED/2.
//     - y = invaders_y + col_bottom[col]*INVADERS_OFFSET_V + SPRITE_HEIGHT_SCALED.
//     - fire=1; cooldown reload; -> WAIT.
//     - If no slot is IDLE by then, abort to WAIT with no fire.
//     - A launched slot does not move until the next frame.
// - Arithmetic: computed at COORD_W+4 bits, truncated to COORD_W.
// - game_clear in any FSM state -> WAIT the next cycle.
// - Async rst mid-flight -> immediate reset state.
// STRUCTURE
// - Shared constants include: RES_V, PROJ_HEIGHT_SCALED, SPRITE_WIDTH_SCALED, SPRITE_HEIGHT_SCALED,
//   INVADERS_OFFSET_H, INVADERS_OFFSET_V.
// - Spawn FSM state encodings are local parameters.
// - Sub-module lfsr16 (clk, rst, seed parameter, q[15:0]) is reusable by other game blocks.
// - Slot array is a generate loop; the lowest-IDLE priority encoder is a function.
// TESTING
// 1 Reset: rst pulse -> m_valid=0, fire=0, all coords 0; after FIRE_COOLDOWN=24 frames -> exactly one fire.
// 2 Launch position:
//   - Setup: col_alive=11'h001, col_bottom[0]=4, invaders_x=40, invaders_y=60.
//   - Expect: slot0 x = 40 + SPRITE_WIDTH_SCALED/2; y = 60 + 4*OFFSET_V + SPRITE_HEIGHT_SCALED.
// 3 Bottom retire:
//   - Setup: active slot at y = RES_V - PROJ_HEIGHT_SCALED - 1.
//   - Expect: next frame -> m_valid[i]=0.
//   - Setup: active slot at y = RES_V - PROJ_HEIGHT_SCALED - 3.
//   - Expect: next frame -> y += 2, still valid.
// 4 Hit vs frame:
//   - Setup: hit[1] and frame in the same cycle.
//   - Expect: slot1 IDLE, y unchanged; other active slots step by 2.
// 5 Pool full, dead board:
//   - Setup: all 3 slots ACTIVE, cooldown 0.
//   - Expect: no fire until a slot retires.
//   - Setup: col_alive=0.
//   - Expect: FSM stays WAIT, fire never pulses.
// 6 game_clear mid-SCAN:
//   - Stimulus: game_clear during SCAN.
//   - Expect: next cycle m_valid=0, FSM WAIT, cooldown=24; LFSR value continues (not reseeded).

Source files
------------

// File: rtl/invader_missile_pool_pkg.sv
// Shared constants, spawn-state encodings and the LFSR step function for the
// invader missile pool and its neighbouring game blocks.
package invader_missile_pool_pkg;

  // Screen and sprite geometry in pixels (sprites drawn at 2x scale)
  localparam int RES_V                = 480;
  localparam int PROJ_HEIGHT_SCALED   = 8;
  localparam int SPRITE_WIDTH_SCALED  = 24;
  localparam int SPRITE_HEIGHT_SCALED = 16;
  localparam int INVADERS_OFFSET_H    = 32;
  localparam int INVADERS_OFFSET_V    = 24;

  // Spawn FSM encodings
  localparam logic [1:0] SPAWN_WAIT   = 2'd0;
  localparam logic [1:0] SPAWN_PICK   = 2'd1;
  localparam logic [1:0] SPAWN_SCAN   = 2'd2;
  localparam logic [1:0] SPAWN_LAUNCH = 2'd3;

  typedef enum logic [1:0] {
    S_WAIT   = SPAWN_WAIT,
    S_PICK   = SPAWN_PICK,
    S_SCAN   = SPAWN_SCAN,
    S_LAUNCH = SPAWN_LAUNCH
  } spawn_state_t;

  // One step of a 16-bit Galois LFSR with taps 16,14,13,11
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
  endfunction

endpackage

// File: rtl/invader_missile_pool_if.sv
// Bus between the formation/game logic (master) and the missile pool (slave).
interface invader_missile_pool_if #(
  parameter int NUM_MISSILES = 3,
  parameter int COORD_W      = 10,
  parameter int NUM_COLS     = 11,
  parameter int ROW_W        = 3
);
  import invader_missile_pool_pkg::*;

  logic                            frame;
  logic                            game_clear;
  logic                            enable;
  logic [COORD_W-1:0]              invaders_x;
  logic [COORD_W-1:0]              invaders_y;
  logic [NUM_COLS-1:0]             col_alive;
  logic [NUM_COLS*ROW_W-1:0]       col_bottom;
  logic [NUM_MISSILES-1:0]         hit;
  logic [NUM_MISSILES-1:0]         m_valid;
  logic [NUM_MISSILES*COORD_W-1:0] m_x;
  logic [NUM_MISSILES*COORD_W-1:0] m_y;
  logic                            fire;

  modport master (
    output frame, game_clear, enable, invaders_x, invaders_y,
           col_alive, col_bottom, hit,
    input  m_valid, m_x, m_y, fire
  );

  modport slave (
    input  frame, game_clear, enable, invaders_x, invaders_y,
           col_alive, col_bottom, hit,
    output m_valid, m_x, m_y, fire
  );

endinterface

// File: rtl/invader_missile_pool_lfsr16.sv
// Free-running 16-bit Galois LFSR, reusable by any game block needing cheap
// pseudo-random values. Advances every clock; only rst reloads the seed.
module lfsr16
  import invader_missile_pool_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Step the sequence every cycle from the nonzero seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= lfsr16_next(q);
  end

endmodule

// File: rtl/invader_missile_pool.sv
// Pool of invader missiles: picks a pseudo-random alive column, launches from
// that column's lowest invader, moves missiles down each frame and retires
// them at the screen bottom or on a player/shield hit.
module invader_missile_pool
  import invader_missile_pool_pkg::*;
#(
  parameter int          NUM_MISSILES  = 3,
  parameter int          COORD_W       = 10,
  parameter int          NUM_COLS      = 11,
  parameter int          ROW_W         = 3,
  parameter int          MISSILE_STEP  = 2,
  parameter int          FIRE_COOLDOWN = 24,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic clk,
  input logic rst,
  invader_missile_pool_if.slave bus
);

  localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int TRY_W  = $clog2(NUM_COLS + 1);
  localparam int SLOT_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
  localparam int WIDE_W = COORD_W + 4;
  localparam logic [WIDE_W-1:0] BOTTOM_LIMIT = WIDE_W'(RES_V - PROJ_HEIGHT_SCALED);

  spawn_state_t            state_q;
  logic [COL_W-1:0]        col_q;
  logic [TRY_W-1:0]        tries_q;
  logic [7:0]              cooldown_q;
  logic                    fire_q;

  logic [15:0]             lfsr_q;
  logic [7:0]              pick_col8;
  logic [NUM_MISSILES-1:0] idle_vec;
  logic                    any_idle;
  logic [SLOT_W-1:0]       launch_slot;
  logic                    launch_go;
  logic [ROW_W-1:0]        bottom_row;
  logic [WIDE_W-1:0]       launch_x_wide;
  logic [WIDE_W-1:0]       launch_y_wide;
  logic [COORD_W-1:0]      launch_x;
  logic [COORD_W-1:0]      launch_y;
  logic                    unused_bits;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Lowest-index idle slot; result is don't-care when no slot is idle
  function automatic logic [SLOT_W-1:0] lowest_idle(input logic [NUM_MISSILES-1:0] idle);
    logic [SLOT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_MISSILES - 1; i >= 0; i--) begin
      if (idle[i]) idx = SLOT_W'(i);
    end
    return idx;
  endfunction

  assign any_idle    = |idle_vec;
  assign launch_slot = lowest_idle(idle_vec);
  assign pick_col8   = lfsr_q[7:0] % 8'(NUM_COLS);

  // Launch only commits if a slot is still free; game_clear cancels it
  assign launch_go = (state_q == S_LAUNCH) && any_idle && !bus.game_clear;

  assign bottom_row    = bus.col_bottom[col_q*ROW_W +: ROW_W];
  assign launch_x_wide = WIDE_W'(bus.invaders_x)
                       + WIDE_W'(col_q) * WIDE_W'(INVADERS_OFFSET_H)
                       + WIDE_W'(SPRITE_WIDTH_SCALED / 2);
  assign launch_y_wide = WIDE_W'(bus.invaders_y)
                       + WIDE_W'(bottom_row) * WIDE_W'(INVADERS_OFFSET_V)
                       + WIDE_W'(SPRITE_HEIGHT_SCALED);
  assign launch_x      = launch_x_wide[COORD_W-1:0];
  assign launch_y      = launch_y_wide[COORD_W-1:0];

  assign unused_bits = ^{lfsr_q[15:8], pick_col8[7:COL_W],
                         launch_x_wide[WIDE_W-1:COORD_W],
                         launch_y_wide[WIDE_W-1:COORD_W]};

  // Spawn FSM with cooldown and the registered fire pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      col_q      <= '0;
      tries_q    <= '0;
      cooldown_q <= 8'(FIRE_COOLDOWN);
      fire_q     <= 1'b0;
    end else begin
      fire_q <= launch_go;

      if (bus.game_clear || launch_go) cooldown_q <= 8'(FIRE_COOLDOWN);
      else if (bus.frame && cooldown_q != 8'd0) cooldown_q <= cooldown_q - 8'd1;

      if (bus.game_clear) begin
        state_q <= S_WAIT;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cooldown_q == 8'd0 && bus.enable && (|bus.col_alive) && any_idle)
              state_q <= S_PICK;
          end
          S_PICK: begin
            col_q   <= pick_col8[COL_W-1:0];
            tries_q <= '0;
            state_q <= S_SCAN;
          end
          S_SCAN: begin
            if (tries_q == TRY_W'(NUM_COLS)) begin
              state_q <= S_WAIT;
            end else if (bus.col_alive[col_q]) begin
              state_q <= S_LAUNCH;
            end else begin
              col_q   <= (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
              tries_q <= tries_q + TRY_W'(1);
            end
          end
          S_LAUNCH: state_q <= S_WAIT;
          default:  state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.fire = fire_q;

  for (genvar i = 0; i < NUM_MISSILES; i++) begin : g_slot
    logic               valid_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [WIDE_W-1:0]  y_step;

    assign y_step = WIDE_W'(y_q) + WIDE_W'(MISSILE_STEP);

    // Slot update: clear beats hit beats launch/move; y holds when retired
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        x_q     <= '0;
        y_q     <= '0;
      end else if (bus.game_clear) begin
        valid_q <= 1'b0;
      end else if (bus.hit[i] && valid_q) begin
        valid_q <= 1'b0;
      end else if (launch_go && launch_slot == SLOT_W'(i)) begin
        valid_q <= 1'b1;
        x_q     <= launch_x;
        y_q     <= launch_y;
      end else if (bus.frame && valid_q) begin
        if (y_step >= BOTTOM_LIMIT) valid_q <= 1'b0;
        else                        y_q     <= y_step[COORD_W-1:0];
      end
    end

    assign idle_vec[i]                    = ~valid_q;
    assign bus.m_valid[i]                 = valid_q;
    assign bus.m_x[i*COORD_W +: COORD_W]  = x_q;
    assign bus.m_y[i*COORD_W +: COORD_W]  = y_q;
  end

endmodule

// File: tb/tb_invader_missile_pool.sv
// Self-checking bench for invader_missile_pool: a behavioural model predicts
// every output each cycle, and directed scenarios pin hand-computed values.
module tb_invader_missile_pool;
  import invader_missile_pool_pkg::*;

  localparam int NM = 3;
  localparam int CW = 10;
  localparam int NC = 11;
  localparam int RW = 3;
  localparam int COOL = 24;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   fire_count = 0;
  bit   check_en = 1'b0;

  // Model state
  bit          mv[NM];
  int          mx[NM];
  int          my[NM];
  bit          mfire;
  int          mcool;
  logic [15:0] mlfsr;
  bit          busy;
  int          pend_col;
  int          launch_cyc;
  int          end_cyc;
  int          cyc;

  invader_missile_pool_if #(.NUM_MISSILES(NM), .COORD_W(CW), .NUM_COLS(NC), .ROW_W(RW)) bus ();

  invader_missile_pool #(
    .NUM_MISSILES(NM), .COORD_W(CW), .NUM_COLS(NC), .ROW_W(RW),
    .MISSILE_STEP(2), .FIRE_COOLDOWN(COOL), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v  = v >> 1;
    if (fb) v = v ^ 16'hB400;
    return v;
  endfunction

  // Behavioural model: a launch is scheduled when triggered, at the cycle the
  // first alive column (searching forward from the random start) is reached
  always @(posedge clk or posedge rst) begin
    bit          gc, any_idle_m, do_launch;
    int          slot, start, c, bot;
    logic [15:0] nxt;
    if (rst) begin
      for (int i = 0; i < NM; i++) begin mv[i] = 0; mx[i] = 0; my[i] = 0; end
      mfire = 0; mcool = COOL; mlfsr = 16'hACE1; busy = 0; pend_col = -1; cyc = 0;
    end else begin
      gc = bus.game_clear;
      any_idle_m = 0; slot = -1;
      for (int i = 0; i < NM; i++) if (!mv[i]) begin any_idle_m = 1; if (slot < 0) slot = i; end
      do_launch = 0;
      if (gc) begin
        busy = 0;
      end else if (busy) begin
        if (pend_col >= 0 && cyc == launch_cyc) begin busy = 0; do_launch = any_idle_m; end
        else if (pend_col < 0 && cyc == end_cyc) busy = 0;
      end else if (mcool == 0 && bus.enable && bus.col_alive != '0 && any_idle_m) begin
        busy = 1; nxt = lfsr_step(mlfsr); start = int'(nxt[7:0]) % NC; pend_col = -1;
        for (int k = 0; k < NC; k++) begin
          c = (start + k) % NC;
          if (bus.col_alive[c] && pend_col < 0) begin pend_col = c; launch_cyc = cyc + 3 + k; end
        end
        if (pend_col < 0) end_cyc = cyc + 13;
      end
      for (int i = 0; i < NM; i++) begin
        if (gc) mv[i] = 0;
        else if (bus.hit[i] && mv[i]) mv[i] = 0;
        else if (do_launch && i == slot) begin
          bot   = int'(bus.col_bottom[pend_col*RW +: RW]);
          mv[i] = 1;
          mx[i] = (int'(bus.invaders_x) + pend_col*INVADERS_OFFSET_H + SPRITE_WIDTH_SCALED/2) % (1 << CW);
          my[i] = (int'(bus.invaders_y) + bot*INVADERS_OFFSET_V + SPRITE_HEIGHT_SCALED) % (1 << CW);
        end else if (bus.frame && mv[i]) begin
          if (my[i] + 2 >= RES_V - PROJ_HEIGHT_SCALED) mv[i] = 0;
          else my[i] = my[i] + 2;
        end
      end
      if (gc || do_launch) mcool = COOL;
      else if (bus.frame && mcool > 0) mcool = mcool - 1;
      mfire = do_launch;
      mlfsr = lfsr_step(mlfsr);
      cyc++;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    logic [NM-1:0]    ev;
    logic [NM*CW-1:0] ex, ey;
    if (check_en) begin
      for (int i = 0; i < NM; i++) begin
        ev[i] = mv[i];
        ex[i*CW +: CW] = CW'(mx[i]);
        ey[i*CW +: CW] = CW'(my[i]);
      end
      vectors++;
      if (bus.m_valid !== ev || bus.m_x !== ex || bus.m_y !== ey || bus.fire !== mfire) begin
        miscompares++;
        $display("[TB] FAIL model t=%0t valid %b want %b, x %h want %h, y %h want %h, fire %b want %b",
                 $time, bus.m_valid, ev, bus.m_x, ex, bus.m_y, ey, bus.fire, mfire);
      end
      if (bus.fire === 1'b1) fire_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One-cycle pulse of frame/hit/game_clear, sampled at exactly one edge
  task automatic applyStimulus(input bit f, input logic [NM-1:0] h, input bit gc);
    bus.frame = f; bus.hit = h; bus.game_clear = gc;
    @(posedge clk); #1;
    bus.frame = 1'b0; bus.hit = '0; bus.game_clear = 1'b0;
  endtask

  // Frames spaced widely so a launched missile is observed before it moves
  task automatic launch_one(output int frames);
    int f0;
    f0 = fire_count; frames = 0;
    while (fire_count == f0 && frames < 40) begin
      applyStimulus(1'b1, '0, 1'b0);
      frames++;
      wait_cycles(16);
    end
    checkOutput("launch_fired", 64'(fire_count - f0), 64'd1);
  endtask

  initial begin
    #500000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fr, f0;
    rst = 1'b1;
    bus.frame = 0; bus.game_clear = 0; bus.enable = 1; bus.hit = '0;
    bus.invaders_x = 10'd40; bus.invaders_y = 10'd60;
    bus.col_alive = 11'h001; bus.col_bottom = 33'd4;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; check_en = 1'b1;

    $display("[TB] reset state and first launch");
    checkOutput("rst_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("rst_fire",  64'(bus.fire), 64'd0);
    checkOutput("rst_x",     64'(bus.m_x), 64'd0);
    checkOutput("rst_y",     64'(bus.m_y), 64'd0);
    launch_one(fr);
    checkOutput("cooldown_frames", 64'(fr), 64'd24);
    checkOutput("launch_valid", 64'(bus.m_valid), 64'b001);
    checkOutput("launch_x", 64'(bus.m_x[0 +: CW]), 64'd52);
    checkOutput("launch_y", 64'(bus.m_y[0 +: CW]), 64'd172);
    wait_cycles(40);
    checkOutput("single_fire", 64'(fire_count), 64'd1);

    $display("[TB] bottom retire");
    bus.col_bottom = '0; bus.invaders_y = 10'd455;
    applyStimulus(1'b0, '0, 1'b1);
    launch_one(fr);
    checkOutput("clear_cooldown_frames", 64'(fr), 64'd24);
    checkOutput("edge_y_471", 64'(bus.m_y[0 +: CW]), 64'd471);
    applyStimulus(1'b1, '0, 1'b0);
    checkOutput("retired_471", 64'(bus.m_valid[0]), 64'd0);
    checkOutput("retired_y_hold", 64'(bus.m_y[0 +: CW]), 64'd471);
    bus.invaders_y = 10'd453;
    launch_one(fr);
    checkOutput("edge_y_469", 64'(bus.m_y[0 +: CW]), 64'd469);
    applyStimulus(1'b1, '0, 1'b0);
    checkOutput("step_to_471_valid", 64'(bus.m_valid[0]), 64'd1);
    checkOutput("step_to_471_y", 64'(bus.m_y[0 +: CW]), 64'd471);
    applyStimulus(1'b1, '0, 1'b0);
    checkOutput("retired_after_471", 64'(bus.m_valid[0]), 64'd0);

    $display("[TB] hit versus frame");
    bus.invaders_y = 10'd60;
    applyStimulus(1'b0, '0, 1'b1);
    launch_one(fr);
    launch_one(fr);
    launch_one(fr);
    checkOutput("three_active", 64'(bus.m_valid), 64'b111);
    applyStimulus(1'b1, 3'b010, 1'b0);
    checkOutput("hit_valid", 64'(bus.m_valid), 64'b101);
    checkOutput("hit_y0", 64'(bus.m_y[0 +: CW]), 64'd174);
    checkOutput("hit_y1_hold", 64'(bus.m_y[CW +: CW]), 64'd124);
    checkOutput("hit_y2", 64'(bus.m_y[2*CW +: CW]), 64'd78);

    $display("[TB] pool full and dead board");
    launch_one(fr);
    checkOutput("refill_slot1_y", 64'(bus.m_y[CW +: CW]), 64'd76);
    f0 = fire_count;
    repeat (30) begin applyStimulus(1'b1, '0, 1'b0); wait_cycles(4); end
    checkOutput("pool_full_no_fire", 64'(fire_count - f0), 64'd0);
    applyStimulus(1'b0, 3'b001, 1'b0);
    wait_cycles(20);
    checkOutput("fire_after_free", 64'(fire_count - f0), 64'd1);
    checkOutput("relaunch_y0", 64'(bus.m_y[0 +: CW]), 64'd76);
    bus.col_alive = '0;
    applyStimulus(1'b0, 3'b111, 1'b0);
    checkOutput("all_hit", 64'(bus.m_valid), 64'd0);
    f0 = fire_count;
    repeat (30) begin applyStimulus(1'b1, '0, 1'b0); wait_cycles(4); end
    checkOutput("dead_board_no_fire", 64'(fire_count - f0), 64'd0);

    $display("[TB] game_clear during scan");
    bus.col_alive = 11'h555; bus.col_bottom = 33'h0_1234_5678;
    f0 = fire_count;
    wait_cycles(20);
    checkOutput("random_col_fire", 64'(fire_count - f0), 64'd1);
    bus.enable = 1'b0;
    repeat (24) begin applyStimulus(1'b1, '0, 1'b0); wait_cycles(1); end
    f0 = fire_count;
    bus.enable = 1'b1;
    wait_cycles(2);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("clear_valid", 64'(bus.m_valid), 64'd0);
    wait_cycles(5);
    checkOutput("clear_no_fire", 64'(fire_count - f0), 64'd0);
    launch_one(fr);
    checkOutput("clear_reload_frames", 64'(fr), 64'd24);

    $display("[TB] asynchronous reset mid-flight");
    #3 rst = 1'b1;
    #1;
    checkOutput("async_valid", 64'(bus.m_valid), 64'd0);
    checkOutput("async_x", 64'(bus.m_x), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    wait_cycles(5);
    checkOutput("after_async_valid", 64'(bus.m_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
